control_unit: RTL and testbench

Hard-wired Mini-SRC control unit that drives every control strobe of the phase-4 datapath from the IR contents and a step counter. It replaces the per-instruction hand-written stimulus FSMs. It sits directly upstream of datapath: its outputs connect one-to-one to the datapath control ports, and its only datapath inputs are IR and the CON flip-flop.

---
 rtl/cpu_pkg.sv | 88 ++++++++
 rtl/cu_decode.sv | 32 +++
 rtl/control_unit.sv | 178 +++++++++++++++++
 tb/tb_control_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared Mini-SRC constants: opcodes, ALU operation codes, T-steps and the
// control-strobe bundle produced by the hard-wired control unit.
package cpu_pkg;

  localparam int unsigned OPW   = 5;
  localparam int unsigned NSTEP = 8;
  localparam int unsigned STW   = $clog2(NSTEP);

  localparam logic [OPW-1:0] LD   = 5'b00000;
  localparam logic [OPW-1:0] LDI  = 5'b00001;
  localparam logic [OPW-1:0] ST   = 5'b00010;
  localparam logic [OPW-1:0] ADD  = 5'b00011;
  localparam logic [OPW-1:0] SUB  = 5'b00100;
  localparam logic [OPW-1:0] AND  = 5'b00101;
  localparam logic [OPW-1:0] OR   = 5'b00110;
  localparam logic [OPW-1:0] SHR  = 5'b00111;
  localparam logic [OPW-1:0] SHRA = 5'b01000;
  localparam logic [OPW-1:0] SHL  = 5'b01001;
  localparam logic [OPW-1:0] ROR  = 5'b01010;
  localparam logic [OPW-1:0] ROL  = 5'b01011;
  localparam logic [OPW-1:0] ADDI = 5'b01100;
  localparam logic [OPW-1:0] ANDI = 5'b01101;
  localparam logic [OPW-1:0] ORI  = 5'b01110;
  localparam logic [OPW-1:0] MUL  = 5'b01111;
  localparam logic [OPW-1:0] DIV  = 5'b10000;
  localparam logic [OPW-1:0] NEG  = 5'b10001;
  localparam logic [OPW-1:0] NOT  = 5'b10010;
  localparam logic [OPW-1:0] BR   = 5'b10011;
  localparam logic [OPW-1:0] JR   = 5'b10100;
  localparam logic [OPW-1:0] JAL  = 5'b10101;
  localparam logic [OPW-1:0] IN   = 5'b10110;
  localparam logic [OPW-1:0] OUT  = 5'b10111;
  localparam logic [OPW-1:0] MFHI = 5'b11000;
  localparam logic [OPW-1:0] MFLO = 5'b11001;
  localparam logic [OPW-1:0] NOP  = 5'b11010;
  localparam logic [OPW-1:0] HALT = 5'b11011;

  // ALU codes reuse the opcode value of the matching instruction
  localparam logic [OPW-1:0] ALU_ADD  = ADD;
  localparam logic [OPW-1:0] ALU_SUB  = SUB;
  localparam logic [OPW-1:0] ALU_AND  = AND;
  localparam logic [OPW-1:0] ALU_OR   = OR;
  localparam logic [OPW-1:0] ALU_SHR  = SHR;
  localparam logic [OPW-1:0] ALU_SHRA = SHRA;
  localparam logic [OPW-1:0] ALU_SHL  = SHL;
  localparam logic [OPW-1:0] ALU_ROR  = ROR;
  localparam logic [OPW-1:0] ALU_ROL  = ROL;
  localparam logic [OPW-1:0] ALU_MUL  = MUL;
  localparam logic [OPW-1:0] ALU_DIV  = DIV;
  localparam logic [OPW-1:0] ALU_NEG  = NEG;
  localparam logic [OPW-1:0] ALU_NOT  = NOT;
  localparam logic [OPW-1:0] ALU_NOP  = 5'b11111;

  localparam logic [STW-1:0] T0 = STW'(0);
  localparam logic [STW-1:0] T1 = STW'(1);
  localparam logic [STW-1:0] T2 = STW'(2);
  localparam logic [STW-1:0] T3 = STW'(3);
  localparam logic [STW-1:0] T4 = STW'(4);
  localparam logic [STW-1:0] T5 = STW'(5);
  localparam logic [STW-1:0] T6 = STW'(6);
  localparam logic [STW-1:0] T7 = STW'(7);

  localparam logic [0:0] MODE_RUN    = 1'b0;
  localparam logic [0:0] MODE_HALTED = 1'b1;

  typedef enum logic [3:0] {
    CL_NONE, CL_RTYPE, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV, CL_UNARY,
    CL_BR, CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_HALT
  } cls_t;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc;
    logic mar_in, mdr_in, mdr_out, mdr_read, ram_write;
    logic ir_in, ry_in, rz_in_lo, rz_in_hi, rz_out_lo, rz_out_hi;
    logic gra, grb, grc, r_in, r_out, ba_out, rc_out;
    logic lo_in, hi_in, lo_out, hi_out, con_in, in_port_out, out_port_in;
  } cu_ctrl_t;

  // Immediate forms map onto the plain ALU operation they share
  function automatic logic [OPW-1:0] imm_alu_op(input logic [OPW-1:0] op);
    case (op)
      ANDI:    return ALU_AND;
      ORI:     return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: instruction class and the T-step that ends execution.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output cls_t           cls,
  output logic [STW-1:0] last_step
);

  always_comb begin
    cls       = CL_NONE;
    last_step = T3;
    case (opcode)
      ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL: begin cls = CL_RTYPE;  last_step = T5; end
      ADDI, ANDI, ORI:                             begin cls = CL_IMM;    last_step = T5; end
      LDI:                                         begin cls = CL_LDI;    last_step = T5; end
      LD:                                          begin cls = CL_LD;     last_step = T7; end
      ST:                                          begin cls = CL_ST;     last_step = T7; end
      MUL, DIV:                                    begin cls = CL_MULDIV; last_step = T6; end
      NEG, NOT:                                    begin cls = CL_UNARY;  last_step = T4; end
      BR:                                          begin cls = CL_BR;     last_step = T6; end
      JR:                                          cls = CL_JR;
      IN:                                          cls = CL_IN;
      OUT:                                         cls = CL_OUT;
      MFHI:                                        cls = CL_MFHI;
      MFLO:                                        cls = CL_MFLO;
      HALT:                                        cls = CL_HALT;
      default:                                     cls = CL_NONE;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hard-wired Mini-SRC control unit: step counter plus run/halt mode, with all
// datapath strobes decoded combinationally from mode, step, opcode and CON.
module control_unit
  import cpu_pkg::*;
(
  input  logic           clock,
  input  logic           clear,
  input  logic [31:0]    ir,
  input  logic           con_ff,
  input  logic           stop,
  output logic           PCout, PCin, IncPC,
  output logic           MARin, MDRin, MDRout, MDRread, RAMwrite,
  output logic           IRin, RYin, RZinLo, RZinHi, RZoutLo, RZoutHi,
  output logic           Gra, Grb, Grc, Rin, Rout, BAout, RCout,
  output logic           LOin, HIin, LOout, HIout, CONin, InPortOut, OutPortIn,
  output logic [OPW-1:0] alu_op,
  output logic           run
);

  logic [0:0]     mode_q, mode_d;
  logic [STW-1:0] step_q, step_d;
  logic [OPW-1:0] opcode;
  cls_t           cls;
  logic [STW-1:0] last_step;
  logic           active;
  cu_ctrl_t       c;
  logic [OPW-1:0] alu;
  logic           unused_ir_bits;

  assign opcode         = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];
  // clear gates the outputs directly so they drop in the same cycle
  assign active         = clear && (mode_q == MODE_RUN);

  cu_decode u_decode (
    .opcode    (opcode),
    .cls       (cls),
    .last_step (last_step)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      mode_q <= MODE_RUN;
      step_q <= T0;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

  // Next state: fetch always runs T0-T2; execute ends at the decoded last step
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    if (mode_q == MODE_RUN) begin
      if (step_q < T3) begin
        step_d = step_q + STW'(1);
      end else if (step_q >= last_step) begin
        step_d = T0;
        if ((step_q == last_step) && (stop || (cls == CL_HALT))) mode_d = MODE_HALTED;
      end else begin
        step_d = step_q + STW'(1);
      end
    end else begin
      step_d = T0;
    end
  end

  // Strobe decode
  always_comb begin
    c   = '0;
    alu = ALU_NOP;
    if (active) begin
      case (step_q)
        T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.rz_in_lo = 1'b1; end
        T1: begin c.rz_out_lo = 1'b1; c.pc_in = 1'b1; c.mdr_read = 1'b1; c.mdr_in = 1'b1; end
        T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
        default: if (step_q <= last_step) begin
          case (cls)
            CL_RTYPE, CL_IMM, CL_LDI, CL_LD, CL_ST: begin
              case (step_q)
                T3: begin
                  c.grb = 1'b1; c.ry_in = 1'b1;
                  if (cls == CL_RTYPE || cls == CL_IMM) c.r_out = 1'b1;
                  else c.ba_out = 1'b1;
                end
                T4: begin
                  c.rz_in_lo = 1'b1;
                  if (cls == CL_RTYPE) begin c.grc = 1'b1; c.r_out = 1'b1; alu = opcode; end
                  else begin c.rc_out = 1'b1; alu = imm_alu_op(opcode); end
                end
                T5: begin
                  c.rz_out_lo = 1'b1;
                  if (cls == CL_LD || cls == CL_ST) c.mar_in = 1'b1;
                  else begin c.gra = 1'b1; c.r_in = 1'b1; end
                end
                T6: begin
                  c.mdr_in = 1'b1;
                  if (cls == CL_LD) c.mdr_read = 1'b1;
                  else begin c.gra = 1'b1; c.r_out = 1'b1; end
                end
                default: begin
                  if (cls == CL_LD) begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                  else c.ram_write = 1'b1;
                end
              endcase
            end
            CL_MULDIV: begin
              case (step_q)
                T3: begin c.gra = 1'b1; c.r_out = 1'b1; c.ry_in = 1'b1; end
                T4: begin
                  c.grb = 1'b1; c.r_out = 1'b1; c.rz_in_lo = 1'b1; c.rz_in_hi = 1'b1;
                  alu = opcode;
                end
                T5: begin c.rz_out_lo = 1'b1; c.lo_in = 1'b1; end
                default: begin c.rz_out_hi = 1'b1; c.hi_in = 1'b1; end
              endcase
            end
            CL_UNARY: begin
              if (step_q == T3) begin
                c.grb = 1'b1; c.r_out = 1'b1; c.rz_in_lo = 1'b1; alu = opcode;
              end else begin
                c.rz_out_lo = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
              end
            end
            CL_BR: begin
              case (step_q)
                T3: begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
                T4: begin c.pc_out = 1'b1; c.ry_in = 1'b1; end
                T5: begin c.rc_out = 1'b1; c.rz_in_lo = 1'b1; alu = ALU_ADD; end
                default: begin c.rz_out_lo = 1'b1; c.pc_in = con_ff; end
              endcase
            end
            CL_JR:   begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
            CL_IN:   begin c.in_port_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            CL_OUT:  begin c.gra = 1'b1; c.r_out = 1'b1; c.out_port_in = 1'b1; end
            CL_MFHI: begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            CL_MFLO: begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            default: ;
          endcase
        end
      endcase
    end
    if (!clear) alu = '0;
  end

  assign PCout     = c.pc_out;
  assign PCin      = c.pc_in;
  assign IncPC     = c.inc_pc;
  assign MARin     = c.mar_in;
  assign MDRin     = c.mdr_in;
  assign MDRout    = c.mdr_out;
  assign MDRread   = c.mdr_read;
  assign RAMwrite  = c.ram_write;
  assign IRin      = c.ir_in;
  assign RYin      = c.ry_in;
  assign RZinLo    = c.rz_in_lo;
  assign RZinHi    = c.rz_in_hi;
  assign RZoutLo   = c.rz_out_lo;
  assign RZoutHi   = c.rz_out_hi;
  assign Gra       = c.gra;
  assign Grb       = c.grb;
  assign Grc       = c.grc;
  assign Rin       = c.r_in;
  assign Rout      = c.r_out;
  assign BAout     = c.ba_out;
  assign RCout     = c.rc_out;
  assign LOin      = c.lo_in;
  assign HIin      = c.hi_in;
  assign LOout     = c.lo_out;
  assign HIout     = c.hi_out;
  assign CONin     = c.con_in;
  assign InPortOut = c.in_port_out;
  assign OutPortIn = c.out_port_in;
  assign alu_op    = alu;
  assign run       = active;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instruction sequences plus random programs,
// checked every cycle against a table model built from the strobe listings.
module tb_control_unit;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir = '0;
  logic        con_ff = 1'b0;
  logic        stop = 1'b0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, RAMwrite;
  logic IRin, RYin, RZinLo, RZinHi, RZoutLo, RZoutHi;
  logic Gra, Grb, Grc, Rin, Rout, BAout, RCout;
  logic LOin, HIin, LOout, HIout, CONin, InPortOut, OutPortIn;
  logic [4:0]  alu_op;
  logic        run;
  logic [27:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  int m_step   = 0;
  bit m_halted = 1'b0;

  string names [28] = '{"PCout", "PCin", "IncPC", "MARin", "MDRin", "MDRout",
    "MDRread", "RAMwrite", "IRin", "RYin", "RZinLo", "RZinHi", "RZoutLo",
    "RZoutHi", "Gra", "Grb", "Grc", "Rin", "Rout", "BAout", "RCout", "LOin",
    "HIin", "LOout", "HIout", "CONin", "InPortOut", "OutPortIn"};

  assign obs = {OutPortIn, InPortOut, CONin, HIout, LOout, HIin, LOin, RCout,
                BAout, Rout, Rin, Grc, Grb, Gra, RZoutHi, RZoutLo, RZinHi,
                RZinLo, RYin, IRin, RAMwrite, MDRread, MDRout, MDRin, MARin,
                IncPC, PCin, PCout};

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .MDRread(MDRread), .RAMwrite(RAMwrite), .IRin(IRin),
    .RYin(RYin), .RZinLo(RZinLo), .RZinHi(RZinHi), .RZoutLo(RZoutLo),
    .RZoutHi(RZoutHi), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .RCout(RCout), .LOin(LOin), .HIin(HIin), .LOout(LOout),
    .HIout(HIout), .CONin(CONin), .InPortOut(InPortOut), .OutPortIn(OutPortIn),
    .alu_op(alu_op), .run(run)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Strobe names active in step s of opcode op; "END" past the final step
  function automatic string step_str(input logic [4:0] op, input int s, input logic con);
    string e [8];
    for (int i = 0; i < 8; i++) e[i] = "END";
    e[0] = "PCout MARin IncPC RZinLo";
    e[1] = "RZoutLo PCin MDRread MDRin";
    e[2] = "MDRout IRin";
    case (op)
      ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL: begin
        e[3] = "Grb Rout RYin"; e[4] = "Grc Rout RZinLo"; e[5] = "RZoutLo Gra Rin";
      end
      ADDI, ANDI, ORI: begin
        e[3] = "Grb Rout RYin"; e[4] = "RCout RZinLo"; e[5] = "RZoutLo Gra Rin";
      end
      LDI: begin
        e[3] = "Grb BAout RYin"; e[4] = "RCout RZinLo"; e[5] = "RZoutLo Gra Rin";
      end
      LD: begin
        e[3] = "Grb BAout RYin"; e[4] = "RCout RZinLo"; e[5] = "RZoutLo MARin";
        e[6] = "MDRread MDRin"; e[7] = "MDRout Gra Rin";
      end
      ST: begin
        e[3] = "Grb BAout RYin"; e[4] = "RCout RZinLo"; e[5] = "RZoutLo MARin";
        e[6] = "Gra Rout MDRin"; e[7] = "RAMwrite";
      end
      MUL, DIV: begin
        e[3] = "Gra Rout RYin"; e[4] = "Grb Rout RZinLo RZinHi";
        e[5] = "RZoutLo LOin"; e[6] = "RZoutHi HIin";
      end
      NEG, NOT: begin e[3] = "Grb Rout RZinLo"; e[4] = "RZoutLo Gra Rin"; end
      BR: begin
        e[3] = "Gra Rout CONin"; e[4] = "PCout RYin"; e[5] = "RCout RZinLo";
        e[6] = con ? "RZoutLo PCin" : "RZoutLo";
      end
      JR:      e[3] = "Gra Rout PCin";
      IN:      e[3] = "InPortOut Gra Rin";
      OUT:     e[3] = "Gra Rout OutPortIn";
      MFHI:    e[3] = "HIout Gra Rin";
      MFLO:    e[3] = "LOout Gra Rin";
      default: e[3] = "";
    endcase
    return (s < 8) ? e[s] : "END";
  endfunction

  function automatic logic [4:0] exp_alu(input logic [4:0] op, input int s);
    if (s == 4) begin
      case (op)
        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV: return op;
        ADDI, LDI, LD, ST: return 5'b00011;
        ANDI:              return 5'b00101;
        ORI:               return 5'b00110;
        default:           return 5'b11111;
      endcase
    end
    if (s == 3 && (op == NEG || op == NOT)) return op;
    if (s == 5 && op == BR) return 5'b00011;
    return 5'b11111;
  endfunction

  function automatic logic [27:0] to_mask(input string s);
    logic [27:0] m;
    int          st;
    m  = '0;
    st = 0;
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == 8'h20) begin
        if (i > st) begin
          string tok;
          tok = s.substr(st, i - 1);
          for (int j = 0; j < 28; j++) if (tok == names[j]) m[j] = 1'b1;
        end
        st = i + 1;
      end
    end
    return m;
  endfunction

  // One clock: drive at negedge, check mid-cycle, advance the model at posedge
  task automatic cycle(input logic [31:0] ir_v, input logic con_v, input logic stop_v,
                       input logic clr_v);
    logic [4:0] op;
    logic       live;
    @(negedge clock);
    ir = ir_v; con_ff = con_v; stop = stop_v; clear = clr_v;
    #1;
    op   = ir_v[31:27];
    live = clr_v && !m_halted;
    check_eq($sformatf("strobes op=%0d T%0d", op, m_step), 32'(obs),
             live ? 32'(to_mask(step_str(op, m_step, con_v))) : 32'd0);
    check_eq($sformatf("alu_op op=%0d T%0d", op, m_step), 32'(alu_op),
             !clr_v ? 32'd0 : (m_halted ? 32'h1f : 32'(exp_alu(op, m_step))));
    check_eq($sformatf("run op=%0d T%0d", op, m_step), 32'(run), 32'(live));
    @(posedge clock);
    if (!clr_v) begin
      m_step = 0; m_halted = 1'b0;
    end else if (!m_halted) begin
      if (step_str(op, m_step + 1, 1'b0) == "END") begin
        m_step = 0;
        if (stop_v || op == HALT) m_halted = 1'b1;
      end else begin
        m_step++;
      end
    end
  endtask

  // con_mode: 0/1 fixed CON, 2 random per cycle; stop raised from step stop_from
  task automatic run_instr(input logic [31:0] ir_v, input int con_mode, input int stop_from);
    logic c;
    for (int k = 0; k < 12; k++) begin
      c = (con_mode == 2) ? 1'($urandom_range(0, 1)) : con_mode[0];
      cycle(ir_v, c, 1'(m_step >= stop_from), 1'b1);
      if (m_step == 0 || m_halted) return;
    end
    check_eq("instr_bound", 32'(m_step), 32'd0);
  endtask

  task automatic idle_then_clear(input int n);
    for (int k = 0; k < n; k++) cycle(ir, 1'($urandom), 1'($urandom), 1'b1);
    cycle(ir, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] rir;
    int          sf;
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    // add up to T4, then clear mid-instruction, then a clean fetch
    for (int k = 0; k < 4; k++) cycle(32'h18918000, 1'b0, 1'b0, 1'b1);
    cycle(32'h18918000, 1'b0, 1'b0, 1'b0);
    run_instr(32'h18918000, 0, 99);
    run_instr(32'h69200071, 0, 99);
    run_instr(32'h00800054, 0, 99);
    run_instr(32'h10800054, 0, 99);
    run_instr(32'h98800010, 0, 99);
    run_instr(32'h98800010, 1, 99);
    run_instr(32'h78918000, 0, 99);
    for (int op = 0; op < 32; op++)
      if (op != 27) run_instr({5'(op), 27'($urandom)}, 2, 99);
    run_instr(32'hD8000000, 0, 99);
    idle_then_clear(20);
    run_instr(32'h20918000, 0, 4);
    idle_then_clear(5);
    for (int n = 0; n < 250; n++) begin
      rir = {5'($urandom_range(0, 31)), 27'($urandom)};
      sf  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 99;
      run_instr(rir, 2, sf);
      if (m_halted) idle_then_clear(int'($urandom_range(1, 4)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
